// File: rtl/display_scan_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scanner.
package display_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low one-cold digit enable for digit i.
    function automatic logic [3:0] an_sel(input logic [1:0] i);
        an_sel = ~(4'b0001 << i);
    endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Loadable down-counter for slot timing; tc is high while the count sits at zero.
module display_scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 4-digit 7-segment scanner with blanking gaps and
// frame-synchronous snapshot updates so digits never change mid-frame.
module display_scan
    import display_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] Segmentos0,
    input  logic [6:0] Segmentos1,
    input  logic [6:0] Segmentos2,
    input  logic [6:0] Segmentos3,
    input  logic       upd_req,
    output logic       upd_ack,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DIGIT_LD = CW'(DIGIT_CYCLES - 1);

    state_t        state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_tc;
    logic          enter_f0;
    logic          cap;
    logic          pending;
    logic [6:0]    snap [4];

    display_scan_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Timer is loaded with N-1 on each state entry so the state lasts N cycles.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = 2'd0;
            tmr_load  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = 2'd0;
                    tmr_load  = 1'b1;
                    tmr_val   = BLANK_LD;
                end
                BLANK: begin
                    if (tmr_tc) begin
                        state_nxt = SHOW;
                        tmr_load  = 1'b1;
                        tmr_val   = DIGIT_LD;
                    end
                end
                SHOW: begin
                    if (tmr_tc) begin
                        state_nxt = BLANK;
                        idx_nxt   = idx + 2'd1;
                        tmr_load  = 1'b1;
                        tmr_val   = BLANK_LD;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = 2'd0;
                    tmr_load  = 1'b1;
                end
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches seg/an combinationally.
    always_comb begin
        seg      = SEG_BLANK;
        an       = AN_OFF;
        enter_f0 = (state_nxt == BLANK) && (idx_nxt == 2'd0) && (state != BLANK);
        cap      = pending && ((state == IDLE) || enter_f0);
        if (state == SHOW) begin
            seg = snap[idx];
            an  = an_sel(idx);
        end
    end

    // A request arriving on the capture edge is absorbed by that capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            upd_ack     <= 1'b0;
            frame_start <= 1'b0;
            for (int i = 0; i < 4; i++) snap[i] <= SEG_BLANK;
        end else begin
            frame_start <= enter_f0;
            upd_ack     <= cap;
            pending     <= cap ? 1'b0 : (pending | upd_req);
            if (cap) begin
                snap[0] <= Segmentos0;
                snap[1] <= Segmentos1;
                snap[2] <= Segmentos2;
                snap[3] <= Segmentos3;
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIGIT_CYCLES=4, BLANK_CYCLES=1 (20-cycle frame).
module tb_display_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       upd_req = 1'b0;
    logic [6:0] s0 = 7'h00, s1 = 7'h00, s2 = 7'h00, s3 = 7'h00;
    logic       upd_ack, frame_start;
    logic [6:0] seg;
    logic [3:0] an;

    int         total = 0;
    int         bad = 0;
    int         pos = 0;
    bit         pend_m = 1'b0;
    logic [6:0] cur [4];
    logic [6:0] nxt [4];

    always #5 clk = ~clk;

    display_scan #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .Segmentos0  (s0),
        .Segmentos1  (s1),
        .Segmentos2  (s2),
        .Segmentos3  (s3),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_segs(input logic [6:0] a, input logic [6:0] b,
                             input logic [6:0] c, input logic [6:0] d);
        s0 = a; s1 = b; s2 = c; s3 = d;
    endtask

    task automatic set_cur(input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] c, input logic [6:0] d);
        cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = d;
    endtask

    task automatic set_nxt(input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] c, input logic [6:0] d);
        nxt[0] = a; nxt[1] = b; nxt[2] = c; nxt[3] = d;
    endtask

    // Frame position p: p%5==0 is the blank slot, p%5 in 1..4 shows digit p/5.
    task automatic scan(input int n);
        int         p;
        int         slot;
        logic       ack_e;
        logic [3:0] ea;
        logic [6:0] es;
        for (int k = 0; k < n; k++) begin
            p     = pos % 20;
            slot  = p / 5;
            ack_e = 1'b0;
            if (p == 0 && pend_m) begin
                for (int j = 0; j < 4; j++) cur[j] = nxt[j];
                pend_m = 1'b0;
                ack_e  = 1'b1;
            end
            ea = 4'hF;
            es = 7'h7F;
            if (p % 5 != 0) begin
                ea = ~(4'b0001 << slot);
                es = cur[slot];
            end
            chk("scan_an", an, ea);
            chk("scan_seg", seg, es);
            chk("scan_frame_start", frame_start, (p == 0) ? 1 : 0);
            chk("scan_upd_ack", upd_ack, ack_e);
            step();
            pos++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_ack", upd_ack, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        #9 rst_n = 1'b1;
        step();
        chk("idle_an", an, 4'hF);
        chk("idle_fs", frame_start, 1'b0);

        // Snapshot load while idle: ack two edges after the request.
        load_segs(7'h40, 7'h79, 7'h24, 7'h30);
        upd_req = 1'b1;
        step();
        upd_req = 1'b0;
        chk("idle_ack_early", upd_ack, 1'b0);
        step();
        chk("idle_ack", upd_ack, 1'b1);
        load_segs(7'h11, 7'h22, 7'h33, 7'h44);
        step();
        chk("idle_ack_single", upd_ack, 1'b0);
        chk("idle_seg", seg, 7'h7F);
        set_cur(7'h40, 7'h79, 7'h24, 7'h30);

        // Start scanning: two full frames.
        enable = 1'b1;
        step();
        pos = 0;
        scan(40);

        // Mid-frame request: old values hold until the next frame start.
        scan(7);
        load_segs(7'h12, 7'h03, 7'h46, 7'h0E);
        set_nxt(7'h12, 7'h03, 7'h46, 7'h0E);
        pend_m  = 1'b1;
        upd_req = 1'b1;
        scan(1);
        upd_req = 1'b0;
        scan(32);

        // Three requests in one frame collapse to a single ack.
        scan(3);
        load_segs(7'h01, 7'h02, 7'h04, 7'h08);
        pend_m  = 1'b1;
        upd_req = 1'b1;
        scan(1);
        upd_req = 1'b0;
        scan(4);
        load_segs(7'h10, 7'h20, 7'h40, 7'h7E);
        upd_req = 1'b1;
        scan(1);
        upd_req = 1'b0;
        scan(5);
        load_segs(7'h5A, 7'h25, 7'h6B, 7'h1C);
        set_nxt(7'h5A, 7'h25, 7'h6B, 7'h1C);
        upd_req = 1'b1;
        scan(1);
        upd_req = 1'b0;
        scan(45);

        // Drop enable while digit 2 is lit, then restart.
        scan(12);
        chk("drop_pre_an", an, 4'hB);
        chk("drop_pre_seg", seg, cur[2]);
        enable = 1'b0;
        step();
        chk("drop_an", an, 4'hF);
        chk("drop_seg", seg, 7'h7F);
        chk("drop_fs", frame_start, 1'b0);
        step();
        chk("drop_idle_an", an, 4'hF);
        chk("drop_idle_fs", frame_start, 1'b0);
        enable = 1'b1;
        step();
        pos = 0;
        scan(20);

        // Asynchronous reset while digit 0 is lit.
        scan(3);
        chk("prerst_an", an, 4'hE);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_an", an, 4'hF);
        chk("arst_seg", seg, 7'h7F);
        chk("arst_ack", upd_ack, 1'b0);
        chk("arst_fs", frame_start, 1'b0);
        #2 rst_n = 1'b1;
        step();
        pos    = 0;
        pend_m = 1'b0;
        set_cur(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        scan(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The module SHALL have parameter DIGIT_CYCLES, default 50000, giving the clock cycles each digit is lit per scan slot (minimum 2).
REQ-002 The module SHALL have parameter BLANK_CYCLES, default 500, giving the anti-ghosting blank cycles before each digit (minimum 1).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  scanning runs while high; display dark while low.
REQ-006 Segmentos0..Segmentos3  input  7 each  active-low segment patterns for digits 0..3 (from the display mux).
REQ-007 upd_req  input  1  single-cycle pulse requesting a new snapshot of Segmentos0..3.
REQ-008 upd_ack  output  1  one-cycle pulse confirming a snapshot was taken.
REQ-009 seg  output  7  shared active-low segment bus.
REQ-010 an  output  4  active-low digit enables; an[i] selects digit i.
REQ-011 frame_start  output  1  one-cycle pulse on the first cycle of each frame.

Function
REQ-012 The controller SHALL use states IDLE, BLANK and SHOW, with a 2-bit digit index idx and a slot cycle counter.
REQ-013 In IDLE with enable high, the next state SHALL be BLANK with idx=0 and the counter cleared.
REQ-014 BLANK SHALL last exactly BLANK_CYCLES cycles, then go to SHOW with idx unchanged.
REQ-015 SHOW SHALL last exactly DIGIT_CYCLES cycles, then go to BLANK with idx+1; idx SHALL wrap 3->0.
REQ-016 frame_start SHALL be high exactly on the first cycle of BLANK with idx=0, including the first frame after IDLE.
REQ-017 In IDLE and BLANK, seg SHALL be 7'h7F and an SHALL be 4'hF.
REQ-018 In SHOW, an SHALL be all ones except bit idx low, and seg SHALL be snapshot[idx], unmodified.
REQ-019 seg and an SHALL be driven from registers or from a decode of registered state only, with no input-to-output combinational path.
REQ-020 upd_req SHALL set a pending flag; several requests before service SHALL collapse into one.
REQ-021 While scanning, a pending request SHALL be served on the clock edge that enters BLANK idx=0; Segmentos0..3 SHALL be sampled on that edge into the snapshot, so the displayed data never changes mid-frame.
REQ-022 In IDLE, a pending request SHALL be served on the next edge.
REQ-023 upd_ack SHALL pulse high for the single cycle after the capture edge, and the pending flag SHALL clear on that capture edge.
REQ-024 If upd_req is high on the capture edge itself, that request SHALL be satisfied by that capture, with no second capture.
REQ-025 If enable falls in any state, the next state SHALL be IDLE, idx and the counter SHALL clear, the snapshot and pending flag SHALL be retained, and no frame_start pulse SHALL occur.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, idx=0, counter=0, every snapshot entry=7'h7F, pending=0, upd_ack=0, frame_start=0, seg=7'h7F, an=4'hF.
REQ-027 After rst_n deasserts, the block SHALL resume from IDLE on the first rising clk edge.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, BLANK, SHOW) and the constants SEG_BLANK=7'h7F and AN_OFF=4'hF.
REQ-029 The slot timing SHALL live in a sub-module display_scan_timer: a loadable down-counter with a terminal-count output, parameterised in width.

Verification
REQ-030 With DIGIT_CYCLES=4 and BLANK_CYCLES=1, on enable rise the bench SHALL check that an follows F,E×4,F,D×4,F,B×4,F,7×4 and repeats with a 20-cycle period, and that frame_start pulses every 20 cycles.
REQ-031 Load Segmentos0..3 = 40,79,24,30 via upd_req in IDLE -> upd_ack 2 cycles later; while an=E seg=40, while an=D seg=79, while an=B seg=24, while an=7 seg=30.
REQ-032 Pulse upd_req mid-frame with new values -> the old values persist until the next frame_start cycle, upd_ack comes one cycle after that edge, and the new values show from digit 0.
REQ-033 Pulse upd_req three times in one frame -> exactly one upd_ack pulse.
REQ-034 Drop enable during SHOW of digit 2 -> next cycle an=F and seg=7F; re-enable -> scan restarts at digit 0 with frame_start and the snapshot intact.
REQ-035 Assert rst_n low mid-SHOW, asynchronous to clk -> an=F and seg=7F immediately; after release, the snapshot is blank (7F) on all digits.
